// File: rtl/ram_arb_pkg.sv
// Shared defaults and requester identifiers for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned AwDefault = 4;
    localparam int unsigned DwDefault = 8;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    // Round-robin favours whichever requester was not served most recently.
    function automatic req_id_e rr_favoured(input req_id_e last_gnt);
        return (last_gnt == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/spram_core.sv
// Single-port synchronous RAM: write or read on each enabled edge, 1-cycle read latency.
module spram_core #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port RAM, round-robin by default.
// Define ARB_FIXED_PRIO_EN to make requester A always win contention.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW = AwDefault,
    parameter int unsigned DW = DwDefault
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata
);

    logic a_win, b_win;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        a_win = a_req;
        b_win = b_req & ~a_req;
    end
`else
    req_id_e last_gnt_q, last_gnt_d;

    always_comb begin
        a_win = a_req & (~b_req | (rr_favoured(last_gnt_q) == REQ_A));
        b_win = b_req & (~a_req | (rr_favoured(last_gnt_q) == REQ_B));
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (a_gnt) begin
            last_gnt_d = REQ_A;
        end else if (b_gnt) begin
            last_gnt_d = REQ_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= REQ_B;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    // Grants are masked while reset is held so no access can slip into the RAM.
    assign a_gnt = rst_n & a_win;
    assign b_gnt = rst_n & b_win;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always_comb begin
        ram_en    = a_gnt | b_gnt;
        ram_we    = a_gnt ? a_we    : b_we;
        ram_addr  = a_gnt ? a_addr  : b_addr;
        ram_wdata = a_gnt ? a_wdata : b_wdata;
    end

    spram_core #(
        .AW (AW),
        .DW (DW)
    ) u_spram_core (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    logic          a_pend_q, b_pend_q;
    logic [DW-1:0] a_hold_q, b_hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_pend_q <= 1'b0;
            b_pend_q <= 1'b0;
        end else begin
            a_pend_q <= a_gnt & ~a_we;
            b_pend_q <= b_gnt & ~b_we;
        end
    end

    // Capture the delivered word so rdata stays put between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_hold_q <= '0;
            b_hold_q <= '0;
        end else begin
            if (a_pend_q) begin
                a_hold_q <= ram_rdata;
            end
            if (b_pend_q) begin
                b_hold_q <= ram_rdata;
            end
        end
    end

    always_comb begin
        a_rvalid = a_pend_q;
        b_rvalid = b_pend_q;
        a_rdata  = a_pend_q ? ram_rdata : a_hold_q;
        b_rdata  = b_pend_q ? ram_rdata : b_hold_q;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed scenarios then random traffic.
module tb_ram_port_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;

    ram_port_arbiter #(
        .AW (AW),
        .DW (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          known;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] mem_m   [16];
    logic          known_m [16];
    int            last_m;           // 0 = A served last, 1 = B
    logic [DW-1:0] mon_ha, mon_hb;
    int            tests, fails;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
        end
    endtask

    // Reference arbitration straight from the rules: lone requester wins,
    // contention goes to whoever was not served last (or always A when fixed).
    function automatic void arb(input logic ar, input logic br, output logic ea,
                                output logic eb);
`ifdef ARB_FIXED_PRIO_EN
        ea = ar;
        eb = br && !ar;
`else
        if (ar && br) begin
            ea = (last_m == 1);
            eb = !ea;
        end else begin
            ea = ar;
            eb = br;
        end
`endif
    endfunction

    task automatic access(input int who, input logic we, input logic [AW-1:0] ad,
                          input logic [DW-1:0] d);
        exp_t e;
        if (we) begin
            mem_m[ad]   = d;
            known_m[ad] = 1'b1;
        end else begin
            e.known = known_m[ad];
            e.data  = mem_m[ad];
            if (who == 0) qa.push_back(e);
            else          qb.push_back(e);
        end
        last_m = who;
    endtask

    task automatic cyc(input logic ar, input logic aw, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input logic br, input logic bw,
                       input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       output logic ga, output logic gb);
        logic ea, eb;
        @(negedge clk);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #1;
        arb(ar, br, ea, eb);
        chk("a_gnt", {31'd0, a_gnt}, {31'd0, ea});
        chk("b_gnt", {31'd0, b_gnt}, {31'd0, eb});
        chk("gnt_onehot", {31'd0, a_gnt & b_gnt}, 32'd0);
        if (ea) access(0, aw, aa, ad);
        if (eb) access(1, bw, ba, bd);
        ga = a_gnt;
        gb = b_gnt;
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_m = 1;
        mon_ha = '0;
        mon_hb = '0;
    endtask

    task automatic idle(input int n);
        logic g1, g2;
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, g1, g2);
    endtask

    // Monitor: any read expected in the queue must surface on this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                mon_ha = '0;
                mon_hb = '0;
            end else begin
                chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, qa.size() != 0});
                if (a_rvalid && qa.size() != 0) begin
                    e = qa.pop_front();
                    if (e.known) chk("a_rdata", {24'd0, a_rdata}, {24'd0, e.data});
                    mon_ha = a_rdata;
                end else if (!a_rvalid) begin
                    chk("a_rdata_hold", {24'd0, a_rdata}, {24'd0, mon_ha});
                end
                chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, qb.size() != 0});
                if (b_rvalid && qb.size() != 0) begin
                    e = qb.pop_front();
                    if (e.known) chk("b_rdata", {24'd0, b_rdata}, {24'd0, e.data});
                    mon_hb = b_rdata;
                end else if (!b_rvalid) begin
                    chk("b_rdata_hold", {24'd0, b_rdata}, {24'd0, mon_hb});
                end
            end
        end
    end

    initial begin
        logic ga, gb;
        logic pa_v, pa_we, pb_v, pb_we;
        logic [AW-1:0] pa_ad, pb_ad;
        logic [DW-1:0] pa_d, pb_d;
        int wa, wb;

        tests = 0;
        fails = 0;
        for (int i = 0; i < 16; i++) begin
            mem_m[i]   = '0;
            known_m[i] = 1'b0;
        end
        model_reset();
        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        #2;
        chk("rst_no_a_gnt", {31'd0, a_gnt}, 32'd0);
        chk("rst_no_b_gnt", {31'd0, b_gnt}, 32'd0);
        chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        chk("rst_a_rdata", {24'd0, a_rdata}, 32'd0);
        chk("rst_b_rdata", {24'd0, b_rdata}, 32'd0);
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Lone write, then read-back by the other requester.
        cyc(1, 1, 4'd2, 8'hAA, 0, 0, 0, 0, ga, gb);
        chk("w2_a_gnt_same_cycle", {31'd0, ga}, 32'd1);
        cyc(0, 0, 0, 0, 1, 0, 4'd2, 0, ga, gb);
        chk("r2_b_gnt", {31'd0, gb}, 32'd1);
        @(posedge clk);
        #3;
        chk("r2_b_rvalid", {31'd0, b_rvalid}, 32'd1);
        chk("r2_b_rdata", {24'd0, b_rdata}, 32'hAA);
        chk("r2_a_rdata_unchanged", {24'd0, a_rdata}, 32'd0);

        // Write by A, immediate read by B.
        cyc(1, 1, 4'd4, 8'h55, 0, 0, 0, 0, ga, gb);
        cyc(0, 0, 0, 0, 1, 0, 4'd4, 0, ga, gb);
        @(posedge clk);
        #3;
        chk("raw4_b_rdata", {24'd0, b_rdata}, 32'h55);
        idle(1);

        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;

`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 4'd2, 0, 1, 0, 4'd4, 0, ga, gb);
            chk("fixed_a_gnt", {31'd0, ga}, 32'd1);
            chk("fixed_b_gnt", {31'd0, gb}, 32'd0);
        end
        cyc(0, 0, 0, 0, 1, 0, 4'd4, 0, ga, gb);
        chk("fixed_b_gnt_after_drop", {31'd0, gb}, 32'd1);
`else
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 4'd2, 0, 1, 0, 4'd4, 0, ga, gb);
            chk("rr_order_a", {31'd0, ga}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_order_b", {31'd0, gb}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
`endif
        idle(1);

        // Reset landing on an in-flight read response kills the pulse.
        cyc(1, 0, 4'd2, 0, 0, 0, 0, 0, ga, gb);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #0.5;
        chk("rst_kills_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_kills_a_rdata", {24'd0, a_rdata}, 32'd0);
        @(negedge clk);
        a_req = 1'b0;
        rst_n = 1'b1;
        idle(1);
        cyc(0, 0, 0, 0, 1, 0, 4'd4, 0, ga, gb);
        idle(1);

        // Reset pulse between a visible read grant and the clock edge.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd2;
        b_req = 1'b0;
        #1;
        chk("pre_pulse_a_gnt", {31'd0, a_gnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("pulse_no_a_gnt", {31'd0, a_gnt}, 32'd0);
        a_req = 1'b0;
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #3;
        chk("pulse_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("pulse_a_rdata", {24'd0, a_rdata}, 32'd0);
        cyc(1, 0, 4'd2, 0, 1, 0, 4'd4, 0, ga, gb);
        chk("pulse_first_contention_a", {31'd0, ga}, 32'd1);
        idle(1);

        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, AW'(i), DW'($urandom), 0, 0, 0, 0, ga, gb);
        end

        pa_v = 0; pb_v = 0; wa = 0; wb = 0;
        pa_we = 0; pb_we = 0; pa_ad = '0; pb_ad = '0; pa_d = '0; pb_d = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pa_v && ($urandom % 4 != 0)) begin
                pa_v = 1; pa_we = 1'($urandom); pa_ad = AW'($urandom); pa_d = DW'($urandom);
            end
            if (!pb_v && ($urandom % 4 != 0)) begin
                pb_v = 1; pb_we = 1'($urandom); pb_ad = AW'($urandom); pb_d = DW'($urandom);
            end
            cyc(pa_v, pa_we, pa_ad, pa_d, pb_v, pb_we, pb_ad, pb_d, ga, gb);
            if (pa_v) begin
                if (ga) begin pa_v = 0; wa = 0; end
                else wa++;
            end
            if (pb_v) begin
                if (gb) begin pb_v = 0; wb = 0; end
                else wb++;
            end
`ifndef ARB_FIXED_PRIO_EN
            chk("a_max_wait", {31'd0, wa <= 1}, 32'd1);
            chk("b_max_wait", {31'd0, wb <= 1}, 32'd1);
`endif
        end
        idle(3);
        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
